// File: rtl/clause_eval_sched.sv
// clause_eval_sched: scans one clause a literal per cycle and classifies it SAT/UNIT/CONFLICT/UNRES.
// Ports: clk, rst (async active-low), clause_valid_i/clause_ready_o (clause handshake),
//   lit_values_i (2 bits per literal: 0 free, 1 false, 2 true, 3 conflict), lit_mask_i (literal present),
//   abort_i (cancel clause in SCAN/DONE), res_valid_o/res_ready_i (result handshake),
//   res_status_o (0 UNRES, 1 UNIT, 2 SAT, 3 CONFLICT), res_unit_idx_o (sole free literal, UNIT only),
//   res_freecnt_o (0 none, 1 one, 3 two-or-more), busy_o (not idle).
// Build option: CLAUSE_EARLY_EXIT_EN ends the scan at the first present true literal.
module clause_eval_sched #(
   parameter int NUM_LITS = 8,
   localparam int IDX_W = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clause_valid_i,
   output logic                  clause_ready_o,
   input  logic [2*NUM_LITS-1:0] lit_values_i,
   input  logic [NUM_LITS-1:0]   lit_mask_i,
   input  logic                  abort_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [1:0]            res_status_o,
   output logic [IDX_W-1:0]      res_unit_idx_o,
   output logic [1:0]            res_freecnt_o,
   output logic                  busy_o
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t                r_state, w_next;
   logic [2*NUM_LITS-1:0] r_vals;
   logic [NUM_LITS-1:0]   r_mask;
   logic [IDX_W-1:0]      r_idx, r_unit;
   logic [1:0]            r_cnt;
   logic                  r_sat, r_confl;
   logic [1:0]            w_lit, w_stat;
   logic                  w_present, w_last, w_exit;
   assign w_lit     = r_vals[{r_idx, 1'b0} +: 2];
   assign w_present = r_mask[r_idx];
   assign w_last    = r_idx == IDX_W'(NUM_LITS - 1);
`ifdef CLAUSE_EARLY_EXIT_EN
   assign w_exit    = w_last | (w_present & (w_lit == 2'd2));
`else
   assign w_exit    = w_last;
`endif
   // A true literal dominates; an explicit conflict or no free literal means CONFLICT.
   assign w_stat = r_sat ? 2'd2 : r_confl ? 2'd3 : (r_cnt == 2'd0) ? 2'd3 : (r_cnt == 2'd1) ? 2'd1 : 2'd0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = clause_valid_i ? SCAN : IDLE;
         SCAN:    w_next = abort_i ? IDLE : w_exit ? DONE : SCAN;
         DONE:    w_next = (abort_i || res_ready_i) ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      clause_ready_o = r_state == IDLE;
      busy_o         = r_state != IDLE;
      res_valid_o    = r_state == DONE;
      res_status_o   = res_valid_o ? w_stat : 2'd0;
      res_freecnt_o  = res_valid_o ? r_cnt : 2'd0;
      res_unit_idx_o = (res_valid_o && w_stat == 2'd1) ? r_unit : '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vals  <= '0;
         r_mask  <= '0;
         r_idx   <= '0;
         r_unit  <= '0;
         r_cnt   <= 2'd0;
         r_sat   <= 1'b0;
         r_confl <= 1'b0;
      end else if (r_state == IDLE && clause_valid_i) begin
         r_vals  <= lit_values_i;
         r_mask  <= lit_mask_i;
         r_idx   <= '0;
         r_unit  <= '0;
         r_cnt   <= 2'd0;
         r_sat   <= 1'b0;
         r_confl <= 1'b0;
      end else if (r_state != IDLE && abort_i) begin
         r_idx   <= '0;
         r_unit  <= '0;
         r_cnt   <= 2'd0;
         r_sat   <= 1'b0;
         r_confl <= 1'b0;
      end else if (r_state == SCAN) begin
         r_idx <= r_idx + IDX_W'(1);
         if (w_present) begin
            // Free count saturates at 3 ("two or more"); the first free literal is the unit candidate.
            if (w_lit == 2'd0) r_cnt <= (r_cnt == 2'd0) ? 2'd1 : 2'd3;
            if (w_lit == 2'd0 && r_cnt == 2'd0) r_unit <= r_idx;
            if (w_lit == 2'd2) r_sat <= 1'b1;
            if (w_lit == 2'd3) r_confl <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_clause_eval_sched.sv
// tb_clause_eval_sched: randomized and directed check of clause_eval_sched against a clause-level model.
module tb_clause_eval_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clause_valid_i = 1'b0;
   logic       clause_ready_o;
   logic [7:0] lit_values_i = '0;
   logic [3:0] lit_mask_i = '0;
   logic       abort_i = 1'b0;
   logic       res_valid_o;
   logic       res_ready_i = 1'b0;
   logic [1:0] res_status_o;
   logic [1:0] res_unit_idx_o;
   logic [1:0] res_freecnt_o;
   logic       busy_o;
   int         tests = 0;
   int         failed = 0;

   clause_eval_sched #(.NUM_LITS(4)) dut (
      .clk(clk), .rst(rst), .clause_valid_i(clause_valid_i), .clause_ready_o(clause_ready_o),
      .lit_values_i(lit_values_i), .lit_mask_i(lit_mask_i), .abort_i(abort_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_status_o(res_status_o),
      .res_unit_idx_o(res_unit_idx_o), .res_freecnt_o(res_freecnt_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Clause-level reference: decide where the scan stops, then classify the literals it saw.
   task automatic model(input logic [7:0] v, input logic [3:0] m,
                        output int st, output int idx, output int fc, output int lat);
      int  stop, nfree, first;
      bit  sat, cf;
      logic [1:0] lv;
      stop = 3; nfree = 0; first = 0; sat = 0; cf = 0;
`ifdef CLAUSE_EARLY_EXIT_EN
      for (int i = 3; i >= 0; i--) if (m[i] && v[2*i +: 2] == 2'd2) stop = i;
`endif
      for (int i = 0; i <= stop; i++) begin
         lv = v[2*i +: 2];
         if (m[i]) begin
            if (lv == 2'd0) begin
               if (nfree == 0) first = i;
               nfree++;
            end
            if (lv == 2'd2) sat = 1;
            if (lv == 2'd3) cf = 1;
         end
      end
      fc  = (nfree == 0) ? 0 : (nfree == 1) ? 1 : 3;
      st  = sat ? 2 : cf ? 3 : (nfree == 0) ? 3 : (nfree == 1) ? 1 : 0;
      idx = (st == 1) ? first : 0;
      lat = stop + 2;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ready"}, clause_ready_o, 1);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_valid"}, res_valid_o, 0);
      chk({tag, "_status"}, res_status_o, 0);
      chk({tag, "_idx"}, res_unit_idx_o, 0);
      chk({tag, "_fc"}, res_freecnt_o, 0);
   endtask

   // Issue a clause (accepted at edge T), then return at the negedge inside cycle T+1.
   task automatic issue(input logic [7:0] v, input logic [3:0] m);
      @(negedge clk);
      clause_valid_i = 1'b1;
      lit_values_i = v;
      lit_mask_i = m;
      chk("accept_ready", clause_ready_o, 1);
      @(posedge clk);
      @(negedge clk);
      clause_valid_i = 1'b0;
      lit_values_i = 8'($urandom);
      lit_mask_i = 4'($urandom);
   endtask

   task automatic run_clause(input logic [7:0] v, input logic [3:0] m, input int hold);
      int st, idx, fc, lat, n;
      model(v, m, st, idx, fc, lat);
      issue(v, m);
      n = 1;
      while (!res_valid_o && n < 20) begin
         chk("busy_scan", busy_o, 1);
         @(negedge clk);
         n++;
      end
      chk("latency", n, lat);
      chk("status", res_status_o, st);
      chk("unit_idx", res_unit_idx_o, idx);
      chk("freecnt", res_freecnt_o, fc);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", res_valid_o, 1);
         chk("hold_status", res_status_o, st);
         chk("hold_idx", res_unit_idx_o, idx);
         chk("hold_fc", res_freecnt_o, fc);
         chk("hold_ready", clause_ready_o, 0);
      end
      res_ready_i = 1'b1;
      @(negedge clk);
      res_ready_i = 1'b0;
      check_idle("after_res");
   endtask

   initial begin
      #12;
      check_idle("reset");
      @(negedge clk);
      rst = 1'b1;
      // Directed cases
      run_clause(8'h45, 4'hF, 0);
      run_clause(8'h55, 4'hF, 0);
      run_clause(8'hA7, 4'h0, 0);
      run_clause(8'h59, 4'hF, 1);
      run_clause(8'h50, 4'hF, 3);
      run_clause(8'h7C, 4'hB, 1);
      // Abort mid-scan at T+2
      issue(8'h45, 4'hF);
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check_idle("abort_scan");
      run_clause(8'h45, 4'hF, 0);
      // Abort together with res_ready in DONE
      issue(8'h55, 4'hF);
      for (int n = 0; n < 20 && !res_valid_o; n++) @(negedge clk);
      chk("done_reached", res_valid_o, 1);
      abort_i = 1'b1;
      res_ready_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      res_ready_i = 1'b0;
      check_idle("abort_done");
      // Async reset mid-scan
      issue(8'h50, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_idle("async_rst");
      @(negedge clk);
      rst = 1'b1;
      run_clause(8'h45, 4'hF, 0);
      // Random clauses
      for (int r = 0; r < 60; r++)
         run_clause(8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
